fetch_stage: RTL

Instruction-fetch stage directly upstream of the fetch/decode pipeline register. It owns the program counter, drives a synchronous instruction memory with one-cycle read latency, and presents `f_pc`/`f_inst` plus the 2-bit `update` code that the fetch/decode register consumes (01 load, 10 bubble, 00 hold). A one-entry hold buffer keeps a returned instruction word intact across decode stalls. Branch, jump and jr redirects from execute flush it.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous imem and presents f_pc/f_inst with an update code.
// Latency 1 cycle issue-to-present; a one-entry hold buffer keeps a returned word across stalls, redirect flushes all.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       f_pc,
    output logic [31:0]       f_inst,
    output logic [1:0]        fd_update
);

    localparam logic [31:0] BUBBLE_PC   = 32'hffff_fffc;
    localparam logic [31:0] BUBBLE_INST = 32'h0000_0001;
    localparam logic [1:0]  UPD_HOLD    = 2'b00;
    localparam logic [1:0]  UPD_LOAD    = 2'b01;
    localparam logic [1:0]  UPD_BUBBLE  = 2'b10;

    logic [31:0] pc_q, pc_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic        cand_vld;
    logic [31:0] cand_pc;
    logic [31:0] cand_inst;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & 32'hffff_fffc;

    // The hold buffer always wins over the returning word: it is older.
    always_comb begin
        cand_vld  = buf_vld_q | rsp_vld_q;
        cand_pc   = buf_vld_q ? buf_pc_q : rsp_pc_q;
        cand_inst = buf_vld_q ? buf_inst_q : imem_data;

        f_pc      = cand_vld ? cand_pc : BUBBLE_PC;
        f_inst    = cand_vld ? cand_inst : BUBBLE_INST;
        imem_en   = redirect | ~stall;
        imem_addr = redirect ? target_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2];

        if (redirect)      fd_update = UPD_BUBBLE;
        else if (stall)    fd_update = UPD_HOLD;
        else if (cand_vld) fd_update = UPD_LOAD;
        else               fd_update = UPD_BUBBLE;

        // Outputs are forced while reset is held, independent of the state registers.
        if (!rstn) begin
            imem_en   = 1'b0;
            fd_update = UPD_BUBBLE;
            f_pc      = BUBBLE_PC;
            f_inst    = BUBBLE_INST;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_pc_d   = rsp_pc_q;
        buf_vld_d  = buf_vld_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        if (redirect) begin
            pc_d      = target_pc + 32'd4;
            rsp_pc_d  = target_pc;
            rsp_vld_d = 1'b1;
            buf_vld_d = 1'b0;
        end else if (stall) begin
            rsp_vld_d = 1'b0;
            if (rsp_vld_q && !buf_vld_q) begin
                buf_vld_d  = 1'b1;
                buf_pc_d   = rsp_pc_q;
                buf_inst_d = imem_data;
            end
        end else begin
            pc_d      = pc_q + 32'd4;
            rsp_pc_d  = pc_q;
            rsp_vld_d = 1'b1;
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            rsp_vld_q  <= 1'b0;
            rsp_pc_q   <= 32'h0;
            buf_vld_q  <= 1'b0;
            buf_pc_q   <= 32'h0;
            buf_inst_q <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_pc_q   <= rsp_pc_d;
            buf_vld_q  <= buf_vld_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

endmodule
